// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit for the execute stage. It runs MULTU, MULT,
// DIVU and DIV over WIDTH cycles and keeps the results in the HI/LO registers.
// The pipeline controller can also load HI/LO directly (MTHI/MTLO).
//
// Ports:
//   CLK   - system clock; all state changes on its rising edge
//   RST_n - synchronous active-low reset
//   Start - launch an operation; ignored while Busy
//   Op    - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A     - rs operand (multiplicand / dividend), also MTHI/MTLO data
//   B     - rt operand (multiplier / divisor)
//   HIWr  - MTHI: HI <= A (only in IDLE without Start)
//   LOWr  - MTLO: LO <= A (only in IDLE without Start)
//   Busy  - operation in progress
//   Done  - one-cycle pulse once HI/LO hold a new result
//   HI    - product upper half / remainder
//   LO    - product lower half / quotient
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIWr,
    input  logic             LOWr,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     counter;
    logic                 is_div;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;

    logic                 launch_signed;
    logic                 launch_neg_a;
    logic                 launch_neg_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quo_fixed;
    logic [WIDTH-1:0]     rem_fixed;
    logic [WIDTH-1:0]     a_orig;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: CALC runs exactly WIDTH edges, FIX takes one edge
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = CALC;
            CALC:    if (counter == CNT_W'(WIDTH - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state != IDLE);
    end

    // Operand sign handling at launch; unsigned ops never see a negative operand
    always_comb begin
        launch_signed = Op[0];
        launch_neg_a  = launch_signed & A[WIDTH-1];
        launch_neg_b  = launch_signed & B[WIDTH-1];
    end

    // One shift-add multiply step: acc = {partial product, remaining multiplier bits}
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // One restoring divide step: acc = {remainder, dividend bits / quotient bits}.
    // The borrow bit of the trial subtraction tells whether the divisor fits.
    always_comb begin
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, mag_b};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up of the magnitude results; a_orig rebuilds the untouched
    // dividend for the divide-by-zero result
    always_comb begin
        prod_fixed = (neg_a ^ neg_b) ? -acc : acc;
        quo_fixed  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        a_orig     = neg_a ? -mag_a : mag_a;
    end

    // Datapath: launch, iterate, write HI/LO; MTHI/MTLO only when idle and not starting
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            counter <= '0;
            is_div  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            HI      <= '0;
            LO      <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        counter <= '0;
                        is_div  <= Op[1];
                        neg_a   <= launch_neg_a;
                        neg_b   <= launch_neg_b;
                        mag_a   <= launch_neg_a ? -A : A;
                        mag_b   <= launch_neg_b ? -B : B;
                        if (Op[1]) begin
                            acc <= {{WIDTH{1'b0}}, (launch_neg_a ? -A : A)};
                        end else begin
                            acc <= {{WIDTH{1'b0}}, (launch_neg_b ? -B : B)};
                        end
                    end else begin
                        if (HIWr) HI <= A;
                        if (LOWr) LO <= A;
                    end
                end
                CALC: begin
                    counter <= counter + 1'b1;
                    acc     <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    Done <= 1'b1;
                    if (!is_div) begin
                        HI <= prod_fixed[2*WIDTH-1:WIDTH];
                        LO <= prod_fixed[WIDTH-1:0];
                    end else if (mag_b == '0) begin
                        HI <= a_orig;
                        LO <= '1;
                    end else begin
                        HI <= rem_fixed;
                        LO <= quo_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Directed self-checking bench for mul_div_unit. Each task drives one scenario
// and compares outputs against hand-computed values, sampling 1 time unit
// after the rising clock edge.
module tb_mul_div_unit;

    logic        CLK;
    logic        RST_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIWr;
    logic        LOWr;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests_run    = 0;
    int tests_failed = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .HIWr  (HIWr),
        .LOWr  (LOWr),
        .Busy  (Busy),
        .Done  (Done),
        .HI    (HI),
        .LO    (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch one operation and wait (bounded) until Busy drops; operands are
    // scrambled right after the launch edge to show they are sampled only once
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output bit hilo_moved);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = HI;
        lo0 = LO;
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        tick();
        Start = 1'b0;
        Op = 2'b00;
        A = 32'h5A5A5A5A;
        B = 32'h0;
        busy_cnt = 0;
        hilo_moved = 1'b0;
        while (Busy && busy_cnt < 100) begin
            busy_cnt++;
            if (HI !== hi0 || LO !== lo0) hilo_moved = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        int done_seen;
        RST_n = 1'b0;
        tick();
        tick();
        RST_n = 1'b1;
        tests_run++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_init: HI=%h LO=%h Busy=%b Done=%b, expected all zero", HI, LO, Busy, Done);
        end
        HIWr = 1'b1;
        LOWr = 1'b1;
        A = 32'h00000055;
        tick();
        HIWr = 1'b0;
        LOWr = 1'b0;
        Start = 1'b1;
        Op = 2'b01;
        A = 32'd5;
        B = 32'd6;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        RST_n = 1'b0;
        tick();
        tick();
        RST_n = 1'b1;
        tests_run++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_midop: HI=%h LO=%h Busy=%b Done=%b, expected all zero", HI, LO, Busy, Done);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) done_seen++;
            tick();
        end
        tests_run++;
        if (done_seen != 0 || HI !== 32'h0 || LO !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_done: done pulses=%0d HI=%h LO=%h, expected 0 pulses and zero HI/LO", done_seen, HI, LO);
        end
    endtask

    task automatic test_multu();
        int busy_cnt;
        bit moved;
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, busy_cnt, moved);
        tests_run++;
        if (busy_cnt != 33) begin
            tests_failed++;
            $display("[TB] FAIL multu_busy_len: got %0d cycles, expected 33", busy_cnt);
        end
        tests_run++;
        if (moved) begin
            tests_failed++;
            $display("[TB] FAIL multu_hilo_hold: HI/LO changed while Busy, expected stable");
        end
        tests_run++;
        if (Done !== 1'b1 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            tests_failed++;
            $display("[TB] FAIL multu_result: Done=%b HI=%h LO=%h, expected 1 fffffffe 00000001", Done, HI, LO);
        end
        tick();
        tests_run++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL multu_done_pulse: Done=%b Busy=%b, expected 0 0", Done, Busy);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        bit moved;
        run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, busy_cnt, moved);
        tests_run++;
        if (Done !== 1'b1 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
            tests_failed++;
            $display("[TB] FAIL mult_neg: Done=%b HI=%h LO=%h, expected 1 ffffffff ffffffeb", Done, HI, LO);
        end
        // Launched from inside the Done cycle
        run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, busy_cnt, moved);
        tests_run++;
        if (busy_cnt != 33 || Done !== 1'b1 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            tests_failed++;
            $display("[TB] FAIL b2b_div: busy=%0d Done=%b HI=%h LO=%h, expected 33 1 ffffffff fffffffd", busy_cnt, Done, HI, LO);
        end
        tick();
    endtask

    task automatic test_divu();
        int busy_cnt;
        bit moved;
        run_op(2'b10, 32'd100, 32'd7, busy_cnt, moved);
        tests_run++;
        if (Done !== 1'b1 || HI !== 32'd2 || LO !== 32'd14) begin
            tests_failed++;
            $display("[TB] FAIL divu_basic: Done=%b HI=%h LO=%h, expected 1 00000002 0000000e", Done, HI, LO);
        end
        tick();
        run_op(2'b10, 32'h12345678, 32'h0, busy_cnt, moved);
        tests_run++;
        if (busy_cnt != 33 || Done !== 1'b1 || HI !== 32'h12345678 || LO !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("[TB] FAIL divu_by_zero: busy=%0d Done=%b HI=%h LO=%h, expected 33 1 12345678 ffffffff", busy_cnt, Done, HI, LO);
        end
        tick();
        run_op(2'b11, 32'hFFFFFFF0, 32'h0, busy_cnt, moved);
        tests_run++;
        if (Done !== 1'b1 || HI !== 32'hFFFFFFF0 || LO !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("[TB] FAIL div_by_zero_neg: Done=%b HI=%h LO=%h, expected 1 fffffff0 ffffffff", Done, HI, LO);
        end
        tick();
    endtask

    task automatic test_div_overflow();
        int done_cnt;
        int done_at;
        logic [31:0] hi_cap;
        logic [31:0] lo_cap;
        Start = 1'b1;
        Op = 2'b11;
        A = 32'h80000000;
        B = 32'hFFFFFFFF;
        tick();
        Start = 1'b0;
        done_cnt = 0;
        done_at = -1;
        hi_cap = 32'h0;
        lo_cap = 32'h0;
        for (int k = 0; k < 60; k++) begin
            if (Done === 1'b1) begin
                done_cnt++;
                done_at = k;
                hi_cap = HI;
                lo_cap = LO;
            end
            if (k == 10) begin
                Start = 1'b1;
                Op = 2'b00;
                A = 32'd3;
                B = 32'd4;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        tests_run++;
        if (done_cnt != 1 || done_at != 33) begin
            tests_failed++;
            $display("[TB] FAIL div_ovf_done: pulses=%0d at=%0d, expected 1 at 33", done_cnt, done_at);
        end
        tests_run++;
        if (hi_cap !== 32'h0 || lo_cap !== 32'h80000000) begin
            tests_failed++;
            $display("[TB] FAIL div_ovf_result: HI=%h LO=%h, expected 00000000 80000000", hi_cap, lo_cap);
        end
    endtask

    task automatic test_mthi_mtlo();
        int busy_cnt;
        bit moved;
        HIWr = 1'b1;
        A = 32'hDEADBEEF;
        tick();
        HIWr = 1'b0;
        tests_run++;
        if (HI !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL mthi: HI=%h, expected deadbeef", HI);
        end
        LOWr = 1'b1;
        A = 32'h00000012;
        tick();
        LOWr = 1'b0;
        tests_run++;
        if (LO !== 32'h00000012 || HI !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL mtlo: HI=%h LO=%h, expected deadbeef 00000012", HI, LO);
        end
        HIWr = 1'b1;
        LOWr = 1'b1;
        A = 32'h00000077;
        tick();
        HIWr = 1'b0;
        LOWr = 1'b0;
        tests_run++;
        if (HI !== 32'h00000077 || LO !== 32'h00000077) begin
            tests_failed++;
            $display("[TB] FAIL mthi_mtlo_both: HI=%h LO=%h, expected 00000077 00000077", HI, LO);
        end
        // MTLO while busy must be ignored
        Start = 1'b1;
        Op = 2'b00;
        A = 32'd2;
        B = 32'd3;
        tick();
        Start = 1'b0;
        tick();
        LOWr = 1'b1;
        A = 32'h0000AAAA;
        tick();
        tick();
        LOWr = 1'b0;
        tests_run++;
        if (LO !== 32'h00000077 || Busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mtlo_busy: LO=%h Busy=%b, expected 00000077 1", LO, Busy);
        end
        busy_cnt = 0;
        while (Busy && busy_cnt < 100) begin
            busy_cnt++;
            tick();
        end
        tests_run++;
        if (Done !== 1'b1 || HI !== 32'h0 || LO !== 32'd6) begin
            tests_failed++;
            $display("[TB] FAIL mtlo_busy_result: Done=%b HI=%h LO=%h, expected 1 00000000 00000006", Done, HI, LO);
        end
        tick();
        // Start beats HIWr in the same cycle
        HIWr = 1'b1;
        Start = 1'b1;
        Op = 2'b10;
        A = 32'd50;
        B = 32'd5;
        tick();
        HIWr = 1'b0;
        Start = 1'b0;
        tests_run++;
        if (HI !== 32'h0 || Busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL start_beats_hiwr: HI=%h Busy=%b, expected 00000000 1", HI, Busy);
        end
        busy_cnt = 0;
        while (Busy && busy_cnt < 100) begin
            busy_cnt++;
            tick();
        end
        tests_run++;
        if (Done !== 1'b1 || HI !== 32'h0 || LO !== 32'd10) begin
            tests_failed++;
            $display("[TB] FAIL start_beats_hiwr_result: Done=%b HI=%h LO=%h, expected 1 00000000 0000000a", Done, HI, LO);
        end
        tick();
        run_op(2'b00, 32'd1, 32'd1, busy_cnt, moved);
        tests_run++;
        if (busy_cnt != 33) begin
            tests_failed++;
            $display("[TB] FAIL final_busy_len: got %0d cycles, expected 33", busy_cnt);
        end
    endtask

    initial begin
        RST_n = 1'b0;
        Start = 1'b0;
        Op = 2'b00;
        A = 32'h0;
        B = 32'h0;
        HIWr = 1'b0;
        LOWr = 1'b0;
        test_reset();
        test_multu();
        test_back_to_back();
        test_divu();
        test_div_overflow();
        test_mthi_mtlo();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the general-purpose register file.
- Takes the two register read operands and produces the HI/LO results of MULT/MULTU/DIV/DIVU.
- HI/LO are read back through the MFHI/MFLO path into the register-file write-data mux.
- The controller stalls the pipeline on Busy and also drives MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_n  in  1  synchronous reset, active-low. Sampled on the CLK rising edge only.
- Start  in  1  launch operation; honoured only when Busy=0.
- Op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  in  WIDTH  operand rs: multiplicand / dividend; also MTHI/MTLO data.
- B  in  WIDTH  operand rt: multiplier / divisor.
- HIWr  in  1  MTHI: HI <= A.
- LOWr  in  1  MTLO: LO <= A.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; HI/LO hold the new result.
- HI  out  WIDTH  product[63:32] / remainder.
- LO  out  WIDTH  product[31:0] / quotient.

Behaviour:
- Reset (RST_n=0 at a rising edge):
  - state=IDLE, counter=0.
  - HI=0, LO=0, Busy=0, Done=0; internal accumulators cleared.
  - Reset mid-operation aborts the operation; no result is written.
- State IDLE:
  - Start=1 at edge N: latch Op, |A|, |B| and result sign flags.
  - Signed ops take two's-complement magnitude; unsigned ops use operands as-is.
  - Go to CALC, counter=0, Busy=1.
- State CALC: exactly WIDTH iterations, one per edge; then go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and remainder.
- State FIX: one edge (edge N+WIDTH+1).
  - Apply signs.
    - MULT: negate the 64-bit product if sign(A)^sign(B).
    - DIV: negate quotient if sign(A)^sign(B); remainder takes sign of A.
  - Write HI/LO, Done=1, Busy=0, return to IDLE.
- Timing:
  - Done is high for exactly the one cycle after edge N+WIDTH+1 (N+33 at default), then 0.
  - Busy is 1 from edge N to edge N+WIDTH+1.
  - HI/LO are unchanged until the FIX edge.
- Width rules:
  - Product is a full 2*WIDTH bits with no truncation.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no trap).
- Divide by zero (DIVU or DIV, B=0):
  - LO=0xFFFFFFFF, HI=A (original, unmodified), regardless of sign.
  - Full latency still applies; Done still pulses.
- Start while Busy=1: ignored; the running operation is unaffected.
- Start and Done-cycle interaction: a Start in the cycle where Done=1 is accepted (state is IDLE), so back-to-back operations are allowed.
- HIWr/LOWr:
  - Effective only in IDLE with Start=0; write A at the edge.
  - HIWr and LOWr together write both HI and LO.
  - Ignored while Busy=1.
  - Start wins over HIWr/LOWr in the same cycle.
- Op is don't-care when Start=0.
- Operands are sampled only at the Start edge; later changes to A/B have no effect.

Test Plan:
- Reset: hold RST_n=0 two edges during a running MULT, release -> HI=0, LO=0, Busy=0, Done=0; no Done pulse follows.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy=1 for 33 cycles; Done pulse one cycle; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then back-to-back Start in the Done cycle with DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=7 -> LO=14, HI=2. DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678 after full latency.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. A Start pulse mid-operation is ignored (result unchanged, single Done).
- MTHI A=0xDEADBEEF in IDLE -> HI=0xDEADBEEF next cycle. MTLO during Busy -> LO unchanged. HIWr together with Start -> HI not written; operation launched.
